// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequencing FSM for a radix-2 Booth multiplier datapath.
// Registers the operands on an accepted start, steps the datapath through
// n compare/add-sub/shift iterations, and latches the finished product.
module booth_seq_ctrl #(
  parameter int N = 6,
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a_in,
  input  logic [n-1:0] b_in,
  input  logic         cmp,
  input  logic         incr,
  input  logic [N-1:0] p_in,
  output logic [n-1:0] Multiplier,
  output logic [n-1:0] Multiplicand,
  output logic         clr,
  output logic         ld,
  output logic         add_sub,
  output logic         shft,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(n);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CMP    = 3'd2;
  localparam logic [2:0] ST_ADDSUB = 3'd3;
  localparam logic [2:0] ST_SHIFT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          err_r;
  logic          accept;

  assign accept  = (state == ST_IDLE) && start;
  assign cnt_inc = cnt + CW'(1);

  // Next-state selection; an early incr drop in CMP aborts straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_LOAD;
      ST_LOAD:   state_nx = ST_CMP;
      ST_CMP: begin
        if (!incr)     state_nx = ST_DONE;
        else if (cmp)  state_nx = ST_ADDSUB;
        else           state_nx = ST_SHIFT;
      end
      ST_ADDSUB: state_nx = ST_SHIFT;
      ST_SHIFT:  state_nx = (cnt_inc == CNT_LAST) ? ST_DONE : ST_CMP;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Iteration counter: cleared on accepted start, bumped once per SHIFT.
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (accept)            cnt <= '0;
    else if (state == ST_SHIFT) cnt <= cnt_inc;
  end

  // Sticky protocol error, cleared only by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst)                              err_r <= 1'b0;
    else if (accept)                      err_r <= 1'b0;
    else if ((state == ST_CMP) && !incr)  err_r <= 1'b1;
    else if ((state == ST_DONE) && incr)  err_r <= 1'b1;
  end

  // Operand capture; held until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      Multiplier   <= '0;
      Multiplicand <= '0;
    end else if (accept) begin
      Multiplier   <= a_in;
      Multiplicand <= b_in;
    end
  end

  // Product capture on the DONE cycle; held until the next DONE.
  always_ff @(posedge clk) begin
    if (rst)                   product <= '0;
    else if (state == ST_DONE) product <= p_in;
  end

  // Moore control decodes. err also reflects a stray incr during DONE so the
  // flag is visible in the same cycle as the done pulse.
  always_comb begin
    clr     = (state == ST_IDLE);
    ld      = (state == ST_LOAD);
    add_sub = (state == ST_ADDSUB);
    shft    = (state == ST_SHIFT);
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    err     = err_r | ((state == ST_DONE) && incr);
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: randomized self-checking bench for booth_seq_ctrl.
// A behavioural datapath model derives cmp from the Booth recoding of the
// multiplier bits and supplies p_in as the signed product.
module tb_booth_seq_ctrl;

  localparam int NB = 3;
  localparam int NP = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cmp;
  logic          incr;
  logic [NB-1:0] a_in;
  logic [NB-1:0] b_in;
  logic [NP-1:0] p_in;
  logic [NB-1:0] Multiplier;
  logic [NB-1:0] Multiplicand;
  logic          clr, ld, add_sub, shft, busy, done, err;
  logic [NP-1:0] product;

  int checks   = 0;
  int failures = 0;
  logic [NP-1:0] last_p;

  booth_seq_ctrl #(.N(NP), .n(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp(cmp), .incr(incr), .p_in(p_in),
    .Multiplier(Multiplier), .Multiplicand(Multiplicand),
    .clr(clr), .ld(ld), .add_sub(add_sub), .shft(shft),
    .busy(busy), .done(done), .err(err), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Booth recoding: iteration i needs add/sub when bits (i, i-1) differ.
  function automatic bit booth_op(input logic [NB-1:0] a, input int i);
    logic prev;
    prev = (i == 0) ? 1'b0 : a[i-1];
    return a[i] ^ prev;
  endfunction

  // mode 0: incr drops after n shifts; mode 1: incr held high;
  // mode 2: incr drops after e shifts (early). rst_shift>0 pulses reset
  // on that SHIFT. Returns in the IDLE cycle following the run.
  task automatic run_mul(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input int mode, input int e, input bit hold,
                         input bit poke, input int rst_shift,
                         output int done_cyc);
    int exq[$];
    int obs[$];
    int lim, k, exp_done, idx, mism, bad, nd, sa, sb, nctl;
    logic [NP-1:0] exp_p;
    logic exp_err;
    done_cyc = -1;
    sa = $signed(a);
    sb = $signed(b);
    exp_p = NP'(sa * sb);
    lim = (mode == 2) ? e : NB;
    k = 0;
    exq.push_back(1);
    for (int i = 0; i < lim; i++) begin
      if (booth_op(a, i)) begin
        exq.push_back(2);
        k++;
      end
      exq.push_back(3);
    end
    exp_done = (mode == 2) ? (2 * e + k + 3) : (2 * NB + 2 + k);
    exp_err  = (mode != 0);

    a_in = a; b_in = b; p_in = exp_p; start = 1'b1; cmp = 1'b0; incr = 1'b1;
    tick();
    start = hold;
    idx = 0; mism = 0; bad = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) begin
        chk("err_clr", err, 0);
        chk("opa_cap", Multiplier, a);
        chk("opb_cap", Multiplicand, b);
        chk("p_hold", product, last_p);
      end
      if (ld)      obs.push_back(1);
      if (add_sub) obs.push_back(2);
      if (shft)    obs.push_back(3);
      nctl = ld + add_sub + shft;
      if (clr || !busy || nctl > 1) bad++;

      cmp  = (idx < NB) ? booth_op(a, idx) : 1'b0;
      incr = (mode == 1) ? 1'b1 : ((mode == 2) ? (idx < e) : (idx < NB));
      if (shft) idx++;
      #1;
      if (done) begin
        done_cyc = c;
        break;
      end

      if (rst_shift > 0 && shft && idx == rst_shift) begin
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; incr = 1'b1; cmp = 1'b0;
        chk("rst_clr", clr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_prod", product, 0);
        chk("rst_done", done, 0);
        chk("rst_ctl", {ld, add_sub, shft}, 0);
        chk("rst_opa", Multiplier, 0);
        last_p = '0;
        nd = 0;
        repeat (2 * NB + 6) begin
          tick();
          if (done || busy) nd++;
        end
        chk("rst_nodone", nd, 0);
        done_cyc = 0;
        return;
      end

      if (poke && (c == 3 || c == 5)) begin
        start = 1'b1; a_in = ~a; b_in = ~b;
      end else begin
        start = hold; a_in = a; b_in = b;
      end
      tick();
    end

    if (done_cyc < 0) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("done_cyc", done_cyc, exp_done);
    if (obs.size() != exq.size()) mism = 1;
    else foreach (exq[i]) if (obs[i] != exq[i]) mism = 1;
    chk("ctl_seq", mism, 0);
    chk("onehot_busy", bad, 0);
    chk("err_done", err, exp_err);
    chk("opa_hold", Multiplier, a);
    chk("opb_hold", Multiplicand, b);

    start = hold; a_in = a; b_in = b;
    tick();
    incr = 1'b1; cmp = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_clr", clr, 1);
    chk("done_pulse", done, 0);
    chk("product", product, exp_p);
    chk("err_sticky", err, exp_err);
    last_p = exp_p;
  endtask

  initial begin
    int dc;
    logic [NB-1:0] ra, rb;
    int rm, re;
    rst = 1'b1; start = 1'b0; cmp = 1'b0; incr = 1'b1;
    a_in = '0; b_in = '0; p_in = '0; last_p = '0;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("rst_clr0", clr, 1);
    chk("rst_ctl0", {ld, add_sub, shft}, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_err0", err, 0);
    chk("rst_ops0", {Multiplier, Multiplicand}, 0);
    chk("rst_prod0", product, 0);
    rst = 1'b0;
    tick();

    run_mul(3'd0, 3'd2, 0, 0, 1'b0, 1'b0, 0, dc);
    chk("zero_a_cyc", dc, 8);
    chk("zero_a_prod", product, 6'b000000);
    run_mul(3'd3, 3'd2, 0, 0, 1'b0, 1'b0, 0, dc);
    chk("pos_cyc", dc, 10);
    chk("pos_prod", product, 6'b000110);
    run_mul(3'd3, 3'b110, 0, 0, 1'b0, 1'b0, 0, dc);
    chk("neg_prod", product, 6'b111010);
    run_mul(3'd3, 3'b110, 1, 0, 1'b0, 1'b0, 0, dc);
    chk("incr_hi_err", err, 1);
    run_mul(3'd3, 3'd2, 2, 1, 1'b0, 1'b0, 0, dc);
    chk("early_cyc", dc, 6);
    run_mul(3'd5, 3'd3, 0, 0, 1'b0, 1'b1, 0, dc);
    run_mul(3'd2, 3'd7, 0, 0, 1'b1, 1'b0, 0, dc);
    run_mul(3'd6, 3'd5, 0, 0, 1'b0, 1'b0, 0, dc);
    run_mul(3'd3, 3'b110, 0, 0, 1'b0, 1'b0, 2, dc);
    run_mul(3'd1, 3'd1, 0, 0, 1'b0, 1'b0, 0, dc);

    repeat (30) begin
      ra = NB'($urandom);
      rb = NB'($urandom);
      rm = $urandom_range(0, 5);
      rm = (rm > 2) ? 0 : rm;
      re = $urandom_range(0, NB - 1);
      run_mul(ra, rb, rm, re, 1'($urandom), 1'($urandom), 0, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter N, default 6, product width (SHALL equal 2*n).
REQ-002 Parameter n, default 3, operand width and number of Booth iterations.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a multiply; sampled only in IDLE.
REQ-006 a_in  input  n  signed multiplier operand.
REQ-007 b_in  input  n  signed multiplicand operand.
REQ-008 cmp  input  1  datapath flag: 1 = current Booth pair needs add/sub.
REQ-009 incr  input  1  datapath flag: 0 = iterations complete.
REQ-010 p_in  input  N  datapath product bus.
REQ-011 Multiplier  output  n  registered operand to datapath.
REQ-012 Multiplicand  output  n  registered operand to datapath.
REQ-013 clr, ld, add_sub, shft  output  1 each  datapath controls.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  sticky protocol-error flag.
REQ-017 product  output  N  registered result.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, CMP, ADDSUB, SHIFT and DONE; all control outputs SHALL be Moore decodes of the state register.
REQ-019 IDLE: clr=1, other controls 0; start=1 at an edge SHALL capture a_in/b_in into Multiplier/Multiplicand, clear err and the iteration counter, then go to LOAD.
REQ-020 LOAD: ld=1 for exactly one cycle, then CMP.
REQ-021 CMP: all controls 0; cmp=1 SHALL go to ADDSUB, cmp=0 SHALL go to SHIFT.
REQ-022 ADDSUB: add_sub=1 for exactly one cycle, then SHIFT.
REQ-023 SHIFT: shft=1 for exactly one cycle; the counter (width clog2(n+1)) SHALL increment, and the FSM SHALL go to DONE when the new count equals n, else to CMP.
REQ-024 DONE: product SHALL capture p_in, done=1 for one cycle, and the FSM SHALL then return to IDLE.
REQ-025 In DONE, incr=1 SHALL set err=1; product is still captured.
REQ-026 In CMP, incr=0 before n shifts SHALL set err=1 and go to DONE.
REQ-027 Latency from the start-sampling edge to the done cycle SHALL be 2n+2+k cycles, where k is the number of ADDSUB visits.
REQ-028 start outside IDLE SHALL be ignored; operands are not re-captured and no extra done is issued.
REQ-029 Multiplier, Multiplicand and product SHALL hold their values until the next accepted start (product until the next DONE).
REQ-030 start asserted continuously SHALL launch back-to-back multiplies with one IDLE cycle between them.
REQ-031 At most one of clr, ld, add_sub, shft SHALL be high in any cycle.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE from any state, including mid-operation, with priority over start.
REQ-033 Reset values: clr=1, ld=add_sub=shft=0, busy=0, done=0, err=0, counter=0, Multiplier=Multiplicand=product=0.
REQ-034 A multiply aborted by reset SHALL produce no done pulse and leave product at 0.

Verification
REQ-035 a_in=0, b_in=2, n=3: no ADDSUB visits; done in cycle 8 after the start edge; product=000000.
REQ-036 a_in=3, b_in=2: ADDSUB visited 2 times; done in cycle 10; product=000110; err=0.
REQ-037 a_in=3, b_in=-2: product=111010 (-6); control sequence is ld, add_sub, shft, shft, add_sub, shft.
REQ-038 rst pulsed during the second SHIFT: next cycle IDLE, clr=1, busy=0, product=0, no done.
REQ-039 Bench holds incr=1 throughout: err=1 in the done cycle; err clears on the next accepted start.
REQ-040 start pulsed while busy, then held high after done: no disturbance mid-run; second run begins after exactly one IDLE cycle.
